// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the two-master system bus arbiter.
package bus_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_e;

    localparam logic MID_FETCH = 1'b0;
    localparam logic MID_LSU   = 1'b1;

    localparam logic [1:0] HB_BYTE = 2'b00;
    localparam logic [1:0] HB_HALF = 2'b01;
    localparam logic [1:0] HB_WORD = 2'b10;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic        re;
        logic [1:0]  hb;
    } mreq_t;

    function automatic logic is_null(input mreq_t r);
        return !r.we && !r.re;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick2.sv
// Combinational round-robin winner select between two requesters.
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last_owner,
    output logic any,
    output logic winner
);

    always_comb begin
        any    = req0 | req1;
        winner = (req0 && req1) ? ~last_owner : req1;
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with request forwarding and
// transfer timeout; owner id doubles as the round-robin pointer.
module bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TO_W           = 5
) (
    input  logic        i_CLK,
    input  logic        i_RST,
    input  logic        i_M0_REQ,
    input  logic [31:0] i_M0_ADDR,
    input  logic [31:0] i_M0_WDATA,
    input  logic        i_M0_WE,
    input  logic        i_M0_RE,
    input  logic [1:0]  i_M0_HB,
    output logic        o_M0_GNT,
    output logic [31:0] o_M0_RDATA,
    output logic        o_M0_ERR,
    input  logic        i_M1_REQ,
    input  logic [31:0] i_M1_ADDR,
    input  logic [31:0] i_M1_WDATA,
    input  logic        i_M1_WE,
    input  logic        i_M1_RE,
    input  logic [1:0]  i_M1_HB,
    output logic        o_M1_GNT,
    output logic [31:0] o_M1_RDATA,
    output logic        o_M1_ERR,
    output logic        o_S_VALID,
    output logic [31:0] o_S_ADDR,
    output logic [31:0] o_S_WDATA,
    output logic        o_S_WE,
    output logic        o_S_RE,
    output logic [1:0]  o_S_HB,
    input  logic [31:0] i_S_RDATA,
    input  logic        i_S_READY,
    output logic        o_OWNER,
    output logic        o_BUSY
);

    import bus_arbiter_pkg::*;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_e          state_q, state_d;
    logic            owner_q, owner_d;
    logic [TO_W-1:0] cnt_q, cnt_d;

    mreq_t       m0, m1, cur, win;
    logic        oth_req, pick_any, pick_win, done;
    logic [1:0]  gnt;
    logic        err, s_valid;
    logic [31:0] rdata;

    rr_pick2 u_pick (
        .req0       (i_M0_REQ),
        .req1       (i_M1_REQ),
        .last_owner (owner_q),
        .any        (pick_any),
        .winner     (pick_win)
    );

    always_comb begin
        m0 = '{req: i_M0_REQ, addr: i_M0_ADDR, wdata: i_M0_WDATA,
               we: i_M0_WE, re: i_M0_RE, hb: i_M0_HB};
        m1 = '{req: i_M1_REQ, addr: i_M1_ADDR, wdata: i_M1_WDATA,
               we: i_M1_WE, re: i_M1_RE, hb: i_M1_HB};
        cur     = (owner_q == MID_LSU) ? m1 : m0;
        win     = (pick_win == MID_LSU) ? m1 : m0;
        oth_req = (owner_q == MID_LSU) ? i_M0_REQ : i_M1_REQ;
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        gnt     = 2'b00;
        err     = 1'b0;
        rdata   = '0;
        s_valid = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (pick_any) begin
                    owner_d = pick_win;
                    // Null requests complete on the arbitration cycle itself
                    if (is_null(win)) gnt[pick_win] = 1'b1;
                    else              state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (!cur.req) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    if (is_null(cur)) begin
                        done = 1'b1;
                    end else begin
                        s_valid = 1'b1;
                        if (i_S_READY) begin
                            done  = 1'b1;
                            rdata = i_S_RDATA;
                        end else if (cnt_q == TO_LAST) begin
                            done = 1'b1;
                            err  = 1'b1;
                        end else begin
                            cnt_d = cnt_q + TO_W'(1);
                        end
                    end
                    if (done) begin
                        gnt[owner_q] = 1'b1;
                        cnt_d        = '0;
                        if (oth_req) owner_d = ~owner_q;
                        else         state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_q <= ST_IDLE;
            owner_q <= MID_LSU;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_M0_GNT   = gnt[MID_FETCH] & ~i_RST;
    assign o_M1_GNT   = gnt[MID_LSU] & ~i_RST;
    assign o_M0_RDATA = o_M0_GNT ? rdata : '0;
    assign o_M1_RDATA = o_M1_GNT ? rdata : '0;
    assign o_M0_ERR   = o_M0_GNT & err;
    assign o_M1_ERR   = o_M1_GNT & err;

    assign o_S_VALID = s_valid;
    assign o_S_ADDR  = s_valid ? cur.addr : '0;
    assign o_S_WDATA = s_valid ? cur.wdata : '0;
    assign o_S_WE    = s_valid & cur.we;
    assign o_S_RE    = s_valid & cur.re & ~cur.we;
    assign o_S_HB    = s_valid ? cur.hb : 2'b00;

    assign o_OWNER = owner_q & ~i_RST;
    assign o_BUSY  = (state_q == ST_XFER);

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized and directed bench for bus_arbiter against a
// transaction-level reference model.
module tb_bus_arbiter;

    import bus_arbiter_pkg::*;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req[2];
    logic [31:0] addr[2];
    logic [31:0] wdata[2];
    logic        we[2];
    logic        re[2];
    logic [1:0]  hb[2];
    logic [31:0] s_rdata;
    logic        s_ready;

    logic        gnt0, gnt1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic        s_valid, s_we, s_re, owner, busy;
    logic [31:0] s_addr, s_wdata;
    logic [1:0]  s_hb;

    always #5 clk = ~clk;

    bus_arbiter #(.TIMEOUT_CYCLES(TO), .TO_W(5)) dut (
        .i_CLK      (clk),
        .i_RST      (rst),
        .i_M0_REQ   (req[0]),
        .i_M0_ADDR  (addr[0]),
        .i_M0_WDATA (wdata[0]),
        .i_M0_WE    (we[0]),
        .i_M0_RE    (re[0]),
        .i_M0_HB    (hb[0]),
        .o_M0_GNT   (gnt0),
        .o_M0_RDATA (rdata0),
        .o_M0_ERR   (err0),
        .i_M1_REQ   (req[1]),
        .i_M1_ADDR  (addr[1]),
        .i_M1_WDATA (wdata[1]),
        .i_M1_WE    (we[1]),
        .i_M1_RE    (re[1]),
        .i_M1_HB    (hb[1]),
        .o_M1_GNT   (gnt1),
        .o_M1_RDATA (rdata1),
        .o_M1_ERR   (err1),
        .o_S_VALID  (s_valid),
        .o_S_ADDR   (s_addr),
        .o_S_WDATA  (s_wdata),
        .o_S_WE     (s_we),
        .o_S_RE     (s_re),
        .o_S_HB     (s_hb),
        .i_S_RDATA  (s_rdata),
        .i_S_READY  (s_ready),
        .o_OWNER    (owner),
        .o_BUSY     (busy)
    );

    logic [6:0] ctl_live;
    assign ctl_live = {busy, s_valid, owner, gnt1, gnt0, err1, err0};

    int checks = 0;
    int failures = 0;

    // Model: active transfer owner (-1 none), cycles already waited, last owner
    int xo, waited, last;
    logic [1:0]  exp_g;
    logic [1:0]  sn_g, sn_e;
    logic [31:0] sn_r0, sn_r1;
    logic        sn_v, sn_b, sn_o;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        xo = -1;
        waited = 0;
        last = 1;
        exp_g = 2'b00;
    endtask

    function automatic logic nul(input int m);
        return !we[m] && !re[m];
    endfunction

    task automatic model_step();
        logic [1:0]  g = 2'b00;
        logic [1:0]  e = 2'b00;
        logic        v = 1'b0;
        logic [31:0] rd = '0;
        logic        eb = (xo >= 0);
        logic        eo = (last == 1);
        int          o = xo;
        int          w;
        bit          fin = 0;
        if (o < 0) begin
            if (req[0] || req[1]) begin
                w = (req[0] && req[1]) ? 1 - last : (req[1] ? 1 : 0);
                last = w;
                if (nul(w)) g[w] = 1'b1;
                else begin
                    xo = w;
                    waited = 0;
                end
            end
        end else if (!req[o]) begin
            xo = -1;
            waited = 0;
        end else begin
            if (nul(o)) fin = 1;
            else begin
                v = 1'b1;
                if (s_ready) begin
                    fin = 1;
                    rd = s_rdata;
                end else if (waited + 1 == TO) begin
                    fin = 1;
                    e[o] = 1'b1;
                end else waited++;
            end
            if (fin) begin
                g[o] = 1'b1;
                waited = 0;
                if (req[1-o]) begin
                    xo = 1 - o;
                    last = xo;
                end else xo = -1;
            end
        end
        check("ctl", {25'd0, ctl_live}, {25'd0, eb, v, eo, g[1], g[0], e[1], e[0]});
        check("rdata0", rdata0, g[0] ? rd : 32'd0);
        check("rdata1", rdata1, g[1] ? rd : 32'd0);
        if (v) begin
            check("s_addr", s_addr, addr[o]);
            check("s_wdata", s_wdata, wdata[o]);
            check("s_ctl", {28'd0, s_we, s_re, s_hb},
                  {28'd0, we[o], re[o] & ~we[o], hb[o]});
        end
        exp_g = g;
    endtask

    task automatic cycle();
        @(negedge clk);
        sn_g = {gnt1, gnt0};
        sn_e = {err1, err0};
        sn_r0 = rdata0;
        sn_r1 = rdata1;
        sn_v = s_valid;
        sn_b = busy;
        sn_o = owner;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int m, input logic w, input logic r,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] h);
        req[m] = 1'b1;
        we[m] = w;
        re[m] = r;
        addr[m] = a;
        wdata[m] = d;
        hb[m] = h;
    endtask

    task automatic idle_m(input int m);
        req[m] = 1'b0;
        we[m] = 1'b0;
        re[m] = 1'b0;
    endtask

    task automatic rand_issue(input int m);
        int k = $urandom % 10;
        logic w, r;
        if (k == 0) begin
            w = 1'b0; r = 1'b0;
        end else if (k == 1) begin
            w = 1'b1; r = 1'b1;
        end else begin
            w = 1'($urandom % 2); r = ~w;
        end
        issue(m, w, r, $urandom, $urandom, 2'($urandom % 3));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_ctl", {25'd0, ctl_live}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    int stall;

    initial begin
        for (int m = 0; m < 2; m++) begin
            idle_m(m);
            addr[m] = '0;
            wdata[m] = '0;
            hb[m] = HB_BYTE;
        end
        s_ready = 1'b0;
        s_rdata = '0;
        do_reset();

        // M1 read, slave answers two cycles after VALID
        issue(1, 1'b0, 1'b1, 32'h100, 32'h0, HB_WORD);
        cycle();
        cycle();
        cycle();
        s_ready = 1'b1;
        s_rdata = 32'hDEADBEEF;
        cycle();
        check("t1_gnt", {30'd0, sn_g}, 32'd2);
        check("t1_rdata", sn_r1, 32'hDEADBEEF);
        idle_m(1);
        s_ready = 1'b0;
        cycle();

        // Tie after reset, READY high: strict alternation from M0
        do_reset();
        s_ready = 1'b1;
        issue(0, 1'b0, 1'b1, 32'h10, 32'h0, HB_WORD);
        issue(1, 1'b0, 1'b1, 32'h20, 32'h0, HB_HALF);
        for (int k = 0; k < 5; k++) begin
            s_rdata = $urandom;
            cycle();
            if (k == 0) check("t2_arb", {30'd0, sn_g}, 32'd0);
            else check("t2_rr", {30'd0, sn_g}, (k % 2) ? 32'd1 : 32'd2);
            for (int m = 0; m < 2; m++)
                if (exp_g[m]) issue(m, 1'b0, 1'b1, $urandom, 32'h0, HB_WORD);
        end
        idle_m(0);
        idle_m(1);
        s_ready = 1'b0;
        cycle();
        cycle();

        // M0 write with no slave response: timeout on 16th XFER cycle
        issue(0, 1'b1, 1'b0, 32'h2000, 32'hCAFEF00D, HB_WORD);
        cycle();
        for (int k = 1; k <= TO; k++) begin
            cycle();
            if (k == TO - 1) check("t3_early", {30'd0, sn_g}, 32'd0);
        end
        check("t3_gnt_err", {28'd0, sn_e, sn_g}, 32'h5);
        check("t3_rdata", sn_r0, 32'd0);
        idle_m(0);
        cycle();
        check("t3_idle", {31'd0, sn_b}, 32'd0);

        // READY on the timeout cycle completes normally
        issue(1, 1'b0, 1'b1, 32'h300, 32'h0, HB_BYTE);
        cycle();
        for (int k = 1; k <= TO; k++) begin
            if (k == TO) begin
                s_ready = 1'b1;
                s_rdata = 32'h12345678;
            end
            cycle();
        end
        check("t4_gnt_err", {28'd0, sn_e, sn_g}, 32'h2);
        check("t4_rdata", sn_r1, 32'h12345678);
        idle_m(1);
        s_ready = 1'b0;
        cycle();

        // Owner abort three cycles into XFER
        issue(1, 1'b0, 1'b1, 32'h400, 32'h0, HB_WORD);
        cycle();
        cycle();
        cycle();
        cycle();
        idle_m(1);
        cycle();
        check("t5_abort", {30'd0, sn_v, |sn_g}, 32'd0);
        cycle();
        check("t5_busy", {31'd0, sn_b}, 32'd0);

        // Null request grants on the arbitration cycle
        issue(0, 1'b0, 1'b0, 32'h500, 32'h0, HB_WORD);
        cycle();
        check("null_gnt", {29'd0, sn_v, sn_g}, 32'd1);
        idle_m(0);
        cycle();

        // Async reset mid-XFER, then tie goes to M0
        issue(0, 1'b0, 1'b1, 32'h600, 32'h0, HB_WORD);
        cycle();
        cycle();
        #2;
        rst = 1'b1;
        #1;
        check("t6_async", {25'd0, ctl_live}, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        s_ready = 1'b1;
        issue(1, 1'b0, 1'b1, 32'h700, 32'h0, HB_WORD);
        cycle();
        cycle();
        check("t6_tie", {30'd0, sn_g}, 32'd1);
        idle_m(0);
        cycle();
        idle_m(1);
        s_ready = 1'b0;
        cycle();

        // Random traffic
        stall = 0;
        for (int n = 0; n < 3000; n++) begin
            for (int m = 0; m < 2; m++) begin
                if (req[m] && exp_g[m]) begin
                    idle_m(m);
                    if ($urandom % 2 == 0) rand_issue(m);
                end else if (req[m] && $urandom % 40 == 0) begin
                    idle_m(m);
                end else if (!req[m] && $urandom % 3 == 0) begin
                    rand_issue(m);
                end
            end
            if (stall > 0) begin
                s_ready = 1'b0;
                stall--;
            end else if ($urandom % 100 == 0) begin
                stall = 20;
                s_ready = 1'b0;
            end else begin
                s_ready = ($urandom % 3 == 0);
            end
            s_rdata = $urandom;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
